// File: rtl/ov7670_rgb444_orange_capture.sv
`timescale 1ns/1ps
// OV7670 RGB444 front end: pairs camera bytes into pixels, tracks column/row, flags orange pixels.
// Define FRAME_STATS_EN to add a per-frame orange pixel total (orange_total / orange_total_valid).
module ov7670_rgb444_orange_capture #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_LINES  = 240,
    parameter int unsigned R_MIN    = 10,
    parameter int unsigned G_MIN    = 3,
    parameter int unsigned G_MAX    = 9,
    parameter int unsigned B_MAX    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cam_data,
    input  logic        cam_href,
    input  logic        cam_vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        is_orange,
    output logic        pixel_valid,
    output logic        href_out,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        frame_done
`ifdef FRAME_STATS_EN
    ,
    output logic [16:0] orange_total,
    output logic        orange_total_valid
`endif
);
    localparam int unsigned N_W   = 4;
    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 8;
    localparam int unsigned CNT_W = 17;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        BYTE_LO,
        BYTE_HI
    } state_t;

    state_t         state;
    logic           vsync_q;
    logic [N_W-1:0] hi_red;
    logic [X_W-1:0] col;
    logic [Y_W-1:0] row;
    logic           emitted;
    logic [N_W-1:0] green_c;
    logic [N_W-1:0] blue_c;
    logic           orange_c;
    logic           in_line_c;
    logic           accept_c;
`ifdef FRAME_STATS_EN
    logic [CNT_W-1:0] orange_count;
`endif

    // Classify the pixel formed by the held red nibble and the low byte on the bus
    always_comb begin
        green_c   = cam_data[7:4];
        blue_c    = cam_data[3:0];
        orange_c  = (hi_red >= N_W'(R_MIN)) && (green_c >= N_W'(G_MIN)) &&
                    (green_c <= N_W'(G_MAX)) && (blue_c <= N_W'(B_MAX)) &&
                    (hi_red > green_c);
        in_line_c = (state == BYTE_LO) || (state == BYTE_HI);
        accept_c  = (col < X_W'(H_PIXELS)) && (row < Y_W'(V_LINES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_FRAME;
            vsync_q     <= 1'b0;
            hi_red      <= '0;
            col         <= '0;
            row         <= '0;
            emitted     <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            is_orange   <= 1'b0;
            pixel_valid <= 1'b0;
            href_out    <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_done  <= 1'b0;
`ifdef FRAME_STATS_EN
            orange_count       <= '0;
            orange_total       <= '0;
            orange_total_valid <= 1'b0;
`endif
        end else begin
            vsync_q     <= cam_vsync;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
`ifdef FRAME_STATS_EN
            orange_total_valid <= 1'b0;
`endif
            if (state != WAIT_FRAME && cam_vsync) begin
                // Frame abort wins over any line activity on the same edge
                state      <= WAIT_FRAME;
                col        <= '0;
                row        <= '0;
                href_out   <= 1'b0;
                emitted    <= 1'b0;
                frame_done <= emitted;
`ifdef FRAME_STATS_EN
                orange_count <= '0;
                if (emitted) begin
                    orange_total       <= orange_count;
                    orange_total_valid <= 1'b1;
                end
`endif
            end else if (in_line_c && !cam_href) begin
                state    <= WAIT_LINE;
                col      <= '0;
                row      <= (row < Y_W'(V_LINES)) ? row + Y_W'(1) : row;
                href_out <= 1'b0;
            end else begin
                case (state)
                    WAIT_FRAME: begin
                        if (vsync_q && !cam_vsync) state <= WAIT_LINE;
                    end
                    WAIT_LINE: begin
                        if (cam_href) begin
                            hi_red <= cam_data[3:0];
                            state  <= BYTE_LO;
                        end
                    end
                    BYTE_LO: begin
                        state <= BYTE_HI;
                        if (accept_c) begin
                            red         <= hi_red;
                            green       <= green_c;
                            blue        <= blue_c;
                            is_orange   <= orange_c;
                            x           <= col;
                            y           <= row;
                            pixel_valid <= 1'b1;
                            href_out    <= 1'b1;
                            emitted     <= 1'b1;
                            col         <= col + X_W'(1);
`ifdef FRAME_STATS_EN
                            if (orange_c) orange_count <= orange_count + CNT_W'(1);
`endif
                        end
                    end
                    BYTE_HI: begin
                        hi_red <= cam_data[3:0];
                        state  <= BYTE_LO;
                    end
                endcase
            end
        end
    end
endmodule
